ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter, the send side of the keyboard link. Sends command bytes to the keyboard
//  (e.g. 0xED set-LEDs, 0xF4 enable) on the shared open-collector PS2_CLK/PS2_DAT lines. Sits beside the
//  keyboard receive path. Asserts busy so the receive path ignores clock edges generated during a send.
// PARAMETERS
//  INHIBIT_CYCLES  5000     CLK cycles PS2_CLK is held low before the start bit (100 us at 50 MHz)
//  TIMEOUT_CYCLES  750000   max CLK cycles from clock release to end of frame (15 ms at 50 MHz)
//  FILTER_CYCLES   8        stable samples required per clock level (only with PS2_TX_GLITCH_FILTER_EN)
// PORTS
//  CLK         in   1  system clock
//  RSTn        in   1  asynchronous active-low reset
//  tx_data     in   8  byte to send; captured on accept
//  tx_valid    in   1  request; accepted when tx_valid & tx_ready at a CLK edge
//  tx_ready    out  1  1 only in IDLE
//  busy        out  1  1 in every state except IDLE
//  tx_done     out  1  one-cycle pulse: frame sent and device ACK seen
//  tx_err      out  1  one-cycle pulse: timeout or missing ACK
//  ps2_clk_i   in   1  PS2_CLK pad input, asynchronous
//  ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release it
//  ps2_dat_i   in   1  PS2_DAT pad input, asynchronous
//  ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release it
// BEHAVIOUR
//  Reset (async, RSTn=0): state=IDLE; tx_ready=1, busy=0, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_dat_oe=0.
//   A reset during a send releases both lines at once. No pulse is issued for the aborted frame.
//  Input sync: each pad input passes through 2 flops. A falling edge (fe) is detected on the synced clock
//   (previous=1, current=0). Input-to-fe latency is 3 CLK cycles.
//  Frame: shift reg {stop=1, parity, D7..D0}. parity = ~^tx_data (odd parity). LSB is sent first.
//  FSM:
//   IDLE    : on accept, capture tx_data, zero the counter -> INHIBIT. tx_ready drops the next cycle.
//   INHIBIT : clk_oe=1. After INHIBIT_CYCLES -> START.
//   START   : dat_oe=1 (start bit 0), clk_oe=1 for 1 cycle. Then release clock (clk_oe=0) and zero the
//             timeout counter -> DATA.
//   DATA    : on each fe, drive the next bit: dat_oe = ~bit. Order is D0..D7, parity, then stop (release).
//             After the 10th fe (stop presented) -> ACK.
//   ACK     : dat_oe=0. On the 11th fe, sample synced dat. dat=0 -> WAIT_IDLE. dat=1 -> ERR.
//   WAIT_IDLE: when synced clk=1 and dat=1 -> DONE.
//   DONE    : tx_done=1 for one cycle -> IDLE.
//   ERR     : tx_err=1 for one cycle, both oe=0 -> IDLE.
//  Timeout: counts from clock release through WAIT_IDLE. Reaching TIMEOUT_CYCLES in any of those states
//   -> ERR.
//  tx_valid is ignored while busy; there is no queue. tx_done and tx_err are never both set in one cycle.
//  A fe in the same cycle as the timeout is not acted on: the timeout wins.
//  The bit counter is 4 bits and saturates; extra fe in WAIT_IDLE are ignored.
// CONFIGURATION
//  PS2_TX_GLITCH_FILTER_EN defined:
//   - Synced clock is debounced. The filtered level changes only after FILTER_CYCLES equal samples.
//   - fe is taken from the filtered level. Latency becomes 3+FILTER_CYCLES cycles.
//   - Pulses shorter than FILTER_CYCLES produce no fe.
//  Not defined: fe comes straight from the 2-flop synchronizer and the filter logic is absent.
//   FILTER_CYCLES is unused.
// TESTING
//  1 tx_data=0xED, device model clocks at 12.5 kHz and ACKs -> dat bits 1,0,1,1,0,1,1,1, parity=1, stop
//    released; tx_done after the line is idle.
//  2 tx_data=0xF4 -> parity=0. Clock held low for exactly INHIBIT_CYCLES (5000). ps2_dat_oe=1 before
//    ps2_clk_oe falls.
//  3 The device never clocks -> tx_err pulse exactly TIMEOUT_CYCLES after clock release; both oe=0; tx_ready=1.
//  4 The device leaves dat high on the 11th fe (no ACK) -> tx_err=1, tx_done never asserted.
//  5 RSTn low mid-DATA (after the 4th fe) -> both oe=0 asynchronously; no pulse. A new 0x00 send
//    (parity=1) completes.
//  6 tx_valid held with 0xFF while busy -> only one frame is sent. With PS2_TX_GLITCH_FILTER_EN, a
//    3-cycle low glitch on clock produces no extra bit.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits, odd parity, stop, device ACK.
// Optional clock debounce is enabled by defining PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe,
    input  logic       ps2_dat_i,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2 || FILTER_CYCLES < 1) begin : g_param_check
            $error("ps2_host_tx: cycle parameters out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       clk_s;
    logic       dat_s;
    logic       clk_prev;
    logic       fe;

    // Pads idle high (pulled up), so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
        end
    end

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

    logic [FLT_W-1:0] flt_cnt;
    logic             clk_flt;

    // The filtered level only follows after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            flt_cnt  <= '0;
            clk_flt  <= 1'b1;
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_flt;
            if (clk_s == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_flt <= clk_s;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fe = clk_prev & ~clk_flt;
`else
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s;
        end
    end

    assign fe = clk_prev & ~clk_s;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       frame;
    logic [3:0]       bit_cnt;
    logic             timeout_hit;

    assign timeout_hit = (cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            frame      <= '0;
            bit_cnt    <= '0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_done <= 1'b0;
                    tx_err  <= 1'b0;
                    if (tx_valid) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        cnt        <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    cnt        <= '0;
                    bit_cnt    <= '0;
                    state      <= S_DATA;
                end
                // From here on the timeout has priority over any edge seen in the same cycle.
                S_DATA: begin
                    if (timeout_hit) begin
                        tx_err     <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fe) begin
                            ps2_dat_oe <= ~frame[0];
                            frame      <= {1'b0, frame[9:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    ps2_dat_oe <= 1'b0;
                    if (timeout_hit) begin
                        tx_err     <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        state      <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fe) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (!dat_s) begin
                                state <= S_WAIT_IDLE;
                            end else begin
                                tx_err     <= 1'b1;
                                ps2_clk_oe <= 1'b0;
                                state      <= S_ERR;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (timeout_hit) begin
                        tx_err     <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fe && bit_cnt != 4'hF) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (clk_s && dat_s) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    tx_done  <= 1'b0;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                S_ERR: begin
                    tx_err     <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    tx_done    <= 1'b0;
                    tx_err     <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares captured bits and outcome pulses against the byte-level protocol rules.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 2000;
    localparam int FLT = 8;
`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_i, ps2_dat_i;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_CYCLES(FLT)) dut (
        .CLK(CLK), .RSTn(RSTn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .tx_done(tx_done), .tx_err(tx_err), .ps2_clk_i(ps2_clk_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_i(ps2_dat_i), .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Per-cycle monitor: output consistency, pulse counting, inhibit/start/release timing.
    int   done_cnt = 0, err_cnt = 0;
    int   inh_run = 0, last_inh = 0, start_run = 0, last_start = 0;
    int   rel_cyc = 0, err_cyc = 0;
    logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic fall_dat_ok = 1'b0;

    always @(negedge CLK) begin
        if (RSTn) begin
            check("ready_is_not_busy", tx_ready, !busy);
            check("done_err_exclusive", tx_done & tx_err, 0);
            check("done_single_cycle", tx_done & prev_done, 0);
            check("err_single_cycle", tx_err & prev_err, 0);
            if (tx_ready || tx_err) check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
        end
        if (tx_done && !prev_done) done_cnt++;
        if (tx_err && !prev_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
        else if (inh_run > 0) begin last_inh = inh_run; inh_run = 0; end
        if (ps2_clk_oe && ps2_dat_oe) start_run++;
        else if (start_run > 0) begin last_start = start_run; start_run = 0; end
        if (prev_clk_oe && !ps2_clk_oe) begin
            rel_cyc = cyc;
            fall_dat_ok = prev_dat_oe;
        end
        prev_clk_oe = ps2_clk_oe;
        prev_dat_oe = ps2_dat_oe;
        prev_done = tx_done;
        prev_err = tx_err;
    end

    // Device model: generates the clock, samples data on each rising edge, optionally ACKs.
    task automatic device_frame(input int half, input bit ack, input int abort_at, input bit glitch,
                                output logic [9:0] bits, output bit ok);
        int n;
        ok = 1'b0;
        bits = '0;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < INH + 100) begin
            tick();
            n++;
        end
        check("start_condition", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        if (n >= INH + 100) return;
        check("start_bit_line", ps2_dat_i, 0);
        repeat (half) tick();
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (half) tick();
            if (i == abort_at) begin
                ok = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            tick();
            bits[i-1] = ps2_dat_i;
            if (glitch && i == 5) begin
                repeat (half / 2) tick();
                dev_clk_low = 1'b1;
                repeat (3) tick();
                dev_clk_low = 1'b0;
                repeat (half - half / 2 - 4) tick();
            end else begin
                repeat (half - 1) tick();
            end
        end
        if (ack) dev_dat_low = 1'b1;
        repeat (half / 2) tick();
        dev_clk_low = 1'b1;
        repeat (half) tick();
        dev_clk_low = 1'b0;
        repeat (half / 2) tick();
        dev_dat_low = 1'b0;
        ok = 1'b1;
    endtask

    function automatic logic [9:0] expected_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    task automatic send_byte(input logic [7:0] d, input int half, input bit ack, input bit glitch,
                             input bit hold, output logic [9:0] bits);
        int  d0, e0, n;
        bit  ok;
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge CLK);
        tick();
        check("ready_drops", tx_ready, 0);
        check("busy_rises", busy, 1);
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
        end
        device_frame(half, ack, 0, glitch, bits, ok);
        check("frame_bits", bits, expected_frame(d));
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
            tick();
            n++;
        end
        if (hold) tx_valid = 1'b0;
        check("done_pulses", done_cnt - d0, ack ? 1 : 0);
        check("err_pulses", err_cnt - e0, ack ? 0 : 1);
        repeat (3) tick();
        check("ready_after_frame", tx_ready, 1);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        bit         ok;
        int         d0, e0, n, busy_seen;

        repeat (3) tick();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_err", tx_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_dat_oe", ps2_dat_oe, 0);
        RSTn = 1'b1;
        repeat (5) tick();

        // 0xED with ACK: data 1,0,1,1,0,1,1,1, parity 1, stop released.
        send_byte(8'hED, 20, 1'b1, 1'b0, 1'b0, bits);
        check("ed_literal", bits, 10'h3ED);

        // 0xF4: parity 0, inhibit length, start bit before clock release.
        send_byte(8'hF4, 20, 1'b1, 1'b0, 1'b0, bits);
        check("f4_literal", bits, 10'h2F4);
        check("inhibit_len", last_inh, INH);
        check("start_len", last_start, 1);
        check("dat_before_clk_release", fall_dat_ok, 1);

        // Device never clocks: timeout measured from clock release.
        e0 = err_cnt;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(posedge CLK);
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (err_cnt == e0 && n < TO + INH + 100) begin
            tick();
            n++;
        end
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_len", err_cyc - rel_cyc, TO);
        check("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
        repeat (2) tick();
        check("timeout_ready", tx_ready, 1);

        // No ACK on the 11th clock.
        d0 = done_cnt;
        send_byte(8'($urandom), 22, 1'b0, 1'b0, 1'b0, bits);
        check("noack_no_done", done_cnt - d0, 0);

        // Reset after the 4th falling edge; D3 of 0xA5 is 0 so the data line is driven.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge CLK);
        tick();
        tx_valid = 1'b0;
        device_frame(20, 1'b1, 4, 1'b0, bits, ok);
        check("abort_reached", ok, 1);
        check("pre_reset_dat_oe", ps2_dat_oe, 1);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_rst_clk_oe", ps2_clk_oe, 0);
        check("async_rst_dat_oe", ps2_dat_oe, 0);
        check("async_rst_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        repeat (4) tick();
        RSTn = 1'b1;
        repeat (30) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_err", err_cnt - e0, 0);
        send_byte(8'h00, 20, 1'b1, 1'b0, 1'b0, bits);
        check("zero_literal", bits, 10'h300);

        // tx_valid held with 0xFF while busy: exactly one frame.
        send_byte(8'hFF, 20, 1'b1, GLITCH, 1'b1, bits);
        check("ff_literal", bits, 10'h3FF);
        busy_seen = 0;
        repeat (INH + 30) begin
            tick();
            busy_seen |= int'(busy);
        end
        check("single_frame", busy_seen, 0);

        // Randomized bytes, device speeds and ACK behaviour.
        for (int k = 0; k < 8; k++) begin
            send_byte(8'($urandom), $urandom_range(14, 30), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, bits);
            repeat ($urandom_range(1, 10)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
